// File: rtl/issue_queue_alloc_if.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue_alloc_if
//  Description : Bundle of the dispatch, wakeup, age-matrix and issue signals
//                of the issue-queue allocator.
//                  slave  : the issue queue itself
//                  master : its environment (dispatch, writeback, age matrix,
//                           downstream execution)
//  Signals     : disp_*        micro-op offered by dispatch / disp_ready back
//                wb_*          result-tag wakeup broadcast
//                alloc_*       insert row and update enable for the age matrix
//                ready_entries ready vector for the age matrix
//                grant_entry   one-hot oldest-ready grant from the age matrix
//                issue_*       issued micro-op handshake and contents
//  Revision    : 1.0 - initial release
// ============================================================================
interface issue_queue_alloc_if #(
    parameter int ENTRIES   = 2,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
);
    localparam int c_IDX_W = $clog2(ENTRIES);

    // dispatch
    logic                 disp_valid;
    logic                 disp_ready;
    logic [TAG_W-1:0]     disp_src1_tag;
    logic                 disp_src1_rdy;
    logic [TAG_W-1:0]     disp_src2_tag;
    logic                 disp_src2_rdy;
    logic [TAG_W-1:0]     disp_dst_tag;
    logic [PAYLOAD_W-1:0] disp_payload;

    // wakeup broadcast
    logic                 wb_valid;
    logic [TAG_W-1:0]     wb_tag;

    // age-matrix side
    logic [c_IDX_W-1:0]   alloc_row;
    logic                 alloc_fire;
    logic [ENTRIES-1:0]   ready_entries;
    logic [ENTRIES-1:0]   grant_entry;

    // issue
    logic                 issue_valid;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_dst_tag;
    logic [PAYLOAD_W-1:0] issue_payload;

    modport slave (
        input  disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
               disp_src2_rdy, disp_dst_tag, disp_payload,
               wb_valid, wb_tag, grant_entry, issue_ready,
        output disp_ready, alloc_row, alloc_fire, ready_entries,
               issue_valid, issue_dst_tag, issue_payload
    );

    modport master (
        output disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag,
               disp_src2_rdy, disp_dst_tag, disp_payload,
               wb_valid, wb_tag, grant_entry, issue_ready,
        input  disp_ready, alloc_row, alloc_fire, ready_entries,
               issue_valid, issue_dst_tag, issue_payload
    );

endinterface : issue_queue_alloc_if
`default_nettype wire

// File: rtl/issue_queue_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : issue_queue_alloc
//  Description : Storage and allocation side of the issue unit. Writes
//                dispatched micro-ops into free rows, tracks source readiness
//                from wakeup broadcasts, exports the insert row and ready
//                vector to the age matrix, and issues/frees the row selected
//                by the age matrix's one-hot grant.
//  Ports       : clk        clock
//                reset      asynchronous, active-low reset
//                flush      synchronous flush, invalidates every row
//                iq         issue_queue_alloc_if.slave (dispatch, wakeup,
//                           age-matrix and issue signals)
//                occupancy  number of valid rows (optional, see below)
//  Options     : `define ISSUE_QUEUE_OCCUPANCY_EN adds the registered
//                occupancy output; without it the port and counter are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_queue_alloc #(
    parameter int ENTRIES   = 2,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  wire logic                         clk,
    input  wire logic                         reset,
    input  wire logic                         flush,
    issue_queue_alloc_if.slave                iq
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    ,
    output logic [$clog2(ENTRIES+1)-1:0]      occupancy
`endif
);

    localparam int c_IDX_W = $clog2(ENTRIES);
    localparam int c_OCC_W = $clog2(ENTRIES+1);

    // ------------------------------------------------------------------------
    // Row state, gathered into vectors/arrays from the per-row registers
    // ------------------------------------------------------------------------
    logic [ENTRIES-1:0]   w_valid;
    logic [ENTRIES-1:0]   w_src1_rdy;
    logic [ENTRIES-1:0]   w_src2_rdy;
    logic [TAG_W-1:0]     w_dst_tag  [ENTRIES];
    logic [PAYLOAD_W-1:0] w_payload  [ENTRIES];

    logic [ENTRIES-1:0]   w_ready;
    logic                 w_any_free;
    logic [c_IDX_W-1:0]   w_alloc_row;
    logic                 w_disp_ready;
    logic                 w_alloc_fire;
    logic                 w_byp_src1_rdy;
    logic                 w_byp_src2_rdy;
    logic [ENTRIES-1:0]   w_dealloc;
    logic                 w_issue_valid;
    logic [TAG_W-1:0]     w_issue_dst_tag;
    logic [PAYLOAD_W-1:0] w_issue_payload;

    // ------------------------------------------------------------------------
    // Allocation: lowest free row, taken from registered valid bits only so
    // a row freed by an issue this cycle cannot be re-used until next cycle.
    // ------------------------------------------------------------------------
    assign w_any_free = ~(&w_valid);

    always_comb begin
        w_alloc_row = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_alloc_row = c_IDX_W'(i);
            end
        end
    end

    assign w_disp_ready = w_any_free & ~flush;
    assign w_alloc_fire = iq.disp_valid & w_disp_ready;

    // A broadcast in the dispatch cycle would otherwise be missed, since the
    // row does not yet hold the tag to compare against.
    assign w_byp_src1_rdy = iq.disp_src1_rdy |
                            (iq.wb_valid & (iq.wb_tag == iq.disp_src1_tag));
    assign w_byp_src2_rdy = iq.disp_src2_rdy |
                            (iq.wb_valid & (iq.wb_tag == iq.disp_src2_tag));

    // ------------------------------------------------------------------------
    // Issue: one-hot grant mux. A grant on a non-ready row still raises
    // issue_valid but must not free the row.
    // ------------------------------------------------------------------------
    assign w_ready       = w_valid & w_src1_rdy & w_src2_rdy;
    assign w_issue_valid = |iq.grant_entry;
    assign w_dealloc     = iq.grant_entry & w_ready & {ENTRIES{iq.issue_ready}};

    always_comb begin
        w_issue_dst_tag = '0;
        w_issue_payload = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (iq.grant_entry[i]) begin
                w_issue_dst_tag = w_issue_dst_tag | w_dst_tag[i];
                w_issue_payload = w_issue_payload | w_payload[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-row registers
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_row
            logic                 r_valid;
            logic                 r_src1_rdy;
            logic                 r_src2_rdy;
            logic [TAG_W-1:0]     r_src1_tag;
            logic [TAG_W-1:0]     r_src2_tag;
            logic [TAG_W-1:0]     r_dst_tag;
            logic [PAYLOAD_W-1:0] r_payload;
            logic                 w_write;
            logic                 w_wake1;
            logic                 w_wake2;

            assign w_write = w_alloc_fire & (w_alloc_row == c_IDX_W'(gi));
            assign w_wake1 = iq.wb_valid & (iq.wb_tag == r_src1_tag);
            assign w_wake2 = iq.wb_valid & (iq.wb_tag == r_src2_tag);

            // Control bits: cleared by reset, flush and dealloc. A write never
            // coincides with a dealloc because only free rows are written.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_valid    <= 1'b0;
                    r_src1_rdy <= 1'b0;
                    r_src2_rdy <= 1'b0;
                end else if (flush) begin
                    r_valid    <= 1'b0;
                    r_src1_rdy <= 1'b0;
                    r_src2_rdy <= 1'b0;
                end else if (w_write) begin
                    r_valid    <= 1'b1;
                    r_src1_rdy <= w_byp_src1_rdy;
                    r_src2_rdy <= w_byp_src2_rdy;
                end else if (w_dealloc[gi]) begin
                    r_valid    <= 1'b0;
                    r_src1_rdy <= 1'b0;
                    r_src2_rdy <= 1'b0;
                end else if (r_valid) begin
                    // ready bits are sticky while the row is live
                    if (w_wake1) begin
                        r_src1_rdy <= 1'b1;
                    end
                    if (w_wake2) begin
                        r_src2_rdy <= 1'b1;
                    end
                end
            end

            // Tag/payload storage is only meaningful while r_valid is set,
            // so it carries no reset.
            always_ff @(posedge clk) begin
                if (w_write) begin
                    r_src1_tag <= iq.disp_src1_tag;
                    r_src2_tag <= iq.disp_src2_tag;
                    r_dst_tag  <= iq.disp_dst_tag;
                    r_payload  <= iq.disp_payload;
                end
            end

            assign w_valid[gi]    = r_valid;
            assign w_src1_rdy[gi] = r_src1_rdy;
            assign w_src2_rdy[gi] = r_src2_rdy;
            assign w_dst_tag[gi]  = r_dst_tag;
            assign w_payload[gi]  = r_payload;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Optional occupancy counter, tracking actual row valid transitions
    // ------------------------------------------------------------------------
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    logic [c_OCC_W-1:0] r_occupancy;
    logic               w_any_dealloc;

    assign w_any_dealloc = |w_dealloc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else if (w_alloc_fire && !w_any_dealloc) begin
            r_occupancy <= r_occupancy + c_OCC_W'(1);
        end else if (!w_alloc_fire && w_any_dealloc) begin
            r_occupancy <= r_occupancy - c_OCC_W'(1);
        end
    end

    assign occupancy = r_occupancy;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign iq.disp_ready    = w_disp_ready;
    assign iq.alloc_row     = w_alloc_row;
    assign iq.alloc_fire    = w_alloc_fire;
    assign iq.ready_entries = w_ready;
    assign iq.issue_valid   = w_issue_valid;
    assign iq.issue_dst_tag = w_issue_dst_tag;
    assign iq.issue_payload = w_issue_payload;

endmodule : issue_queue_alloc
`default_nettype wire

// File: tb/tb_issue_queue_alloc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_queue_alloc
//  Description : Directed, self-checking bench for issue_queue_alloc with
//                ENTRIES=2. Inputs change 1 time unit after the rising edge;
//                outputs are checked 2 time units later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_queue_alloc;

    localparam int c_ENTRIES   = 2;
    localparam int c_TAG_W     = 6;
    localparam int c_PAYLOAD_W = 32;

    logic clk;
    logic reset;
    logic flush;

    int n_tests = 0;
    int n_fail  = 0;

    issue_queue_alloc_if #(
        .ENTRIES   (c_ENTRIES),
        .TAG_W     (c_TAG_W),
        .PAYLOAD_W (c_PAYLOAD_W)
    ) iq ();

`ifdef ISSUE_QUEUE_OCCUPANCY_EN
    logic [$clog2(c_ENTRIES+1)-1:0] occupancy;
`endif

    issue_queue_alloc #(
        .ENTRIES   (c_ENTRIES),
        .TAG_W     (c_TAG_W),
        .PAYLOAD_W (c_PAYLOAD_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .iq        (iq)
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_occ(input string tag, input int exp);
`ifdef ISSUE_QUEUE_OCCUPANCY_EN
        check(tag, 32'(occupancy), 32'(exp));
`else
        if (exp < 0) $display("unused %s", tag);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic dispatch(input logic v, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2,
                            input logic [5:0] dst, input logic [31:0] pay);
        iq.disp_valid    = v;
        iq.disp_src1_tag = t1;
        iq.disp_src1_rdy = r1;
        iq.disp_src2_tag = t2;
        iq.disp_src2_rdy = r2;
        iq.disp_dst_tag  = dst;
        iq.disp_payload  = pay;
    endtask

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        dispatch(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        iq.wb_valid    = 1'b0;
        iq.wb_tag      = 6'd0;
        iq.grant_entry = 2'b00;
        iq.issue_ready = 1'b0;

        // ---- reset state ----
        #12;
        check("rst_disp_ready", 32'(iq.disp_ready), 32'd1);
        check("rst_alloc_row",  32'(iq.alloc_row), 32'd0);
        check("rst_ready",      32'(iq.ready_entries), 32'd0);
        check("rst_issue_v",    32'(iq.issue_valid), 32'd0);
        check("rst_alloc_fire", 32'(iq.alloc_fire), 32'd0);
        check_occ("rst_occ", 0);
        reset = 1'b1;
        step();

        // ---- fill: A into row 0, B into row 1 ----
        dispatch(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd10, 32'hAAAA_0000);
        settle();
        check("a_row",  32'(iq.alloc_row), 32'd0);
        check("a_fire", 32'(iq.alloc_fire), 32'd1);
        step();
        dispatch(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd11, 32'hBBBB_0000);
        settle();
        check("b_row",   32'(iq.alloc_row), 32'd1);
        check("b_ready", 32'(iq.ready_entries), 32'b01);
        step();
        settle();
        check("full_ready",      32'(iq.ready_entries), 32'b11);
        check("full_disp_ready", 32'(iq.disp_ready), 32'd0);
        check("full_fire",       32'(iq.alloc_fire), 32'd0);
        check_occ("full_occ", 2);

        // ---- full queue: issue row 1 while dispatch C waits ----
        dispatch(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd12, 32'hCCCC_0000);
        iq.grant_entry = 2'b10;
        iq.issue_ready = 1'b1;
        settle();
        check("g10_subset",  32'(iq.grant_entry & ~iq.ready_entries), 32'd0);
        check("g10_valid",   32'(iq.issue_valid), 32'd1);
        check("g10_payload", iq.issue_payload, 32'hBBBB_0000);
        check("g10_dst",     32'(iq.issue_dst_tag), 32'd11);
        check("g10_no_reuse", 32'(iq.disp_ready), 32'd0);
        step();
        iq.grant_entry = 2'b00;
        iq.issue_ready = 1'b0;
        settle();
        check("freed_ready", 32'(iq.ready_entries), 32'b01);
        check("c_row",       32'(iq.alloc_row), 32'd1);
        check("c_fire",      32'(iq.alloc_fire), 32'd1);
        check_occ("freed_occ", 1);
        step();
        dispatch(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        settle();
        check("c_ready", 32'(iq.ready_entries), 32'b11);
        check_occ("c_occ", 2);

        // ---- grant row 0 held with issue_ready=0 for 3 cycles ----
        iq.grant_entry = 2'b01;
        for (int k = 0; k < 4; k++) begin
            iq.issue_ready = (k == 3);
            settle();
            check("hold_valid",   32'(iq.issue_valid), 32'd1);
            check("hold_payload", iq.issue_payload, 32'hAAAA_0000);
            check("hold_rows",    32'(iq.ready_entries), 32'b11);
            step();
        end
        iq.grant_entry = 2'b00;
        iq.issue_ready = 1'b0;
        settle();
        check("hold_freed", 32'(iq.ready_entries), 32'b10);
        check_occ("hold_occ", 1);

        // ---- refill row 0 with D, then flush with dispatch + issue ----
        dispatch(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd13, 32'hDDDD_0000);
        step();
        dispatch(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd14, 32'hEEEE_0000);
        flush          = 1'b1;
        iq.grant_entry = 2'b01;
        iq.issue_ready = 1'b1;
        settle();
        check("fl_disp_ready", 32'(iq.disp_ready), 32'd0);
        check("fl_fire",       32'(iq.alloc_fire), 32'd0);
        check("fl_issue",      32'(iq.issue_valid), 32'd1);
        check("fl_payload",    iq.issue_payload, 32'hDDDD_0000);
        step();
        flush          = 1'b0;
        iq.grant_entry = 2'b00;
        iq.issue_ready = 1'b0;
        dispatch(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        settle();
        check("post_fl_ready", 32'(iq.ready_entries), 32'd0);
        check("post_fl_disp",  32'(iq.disp_ready), 32'd1);
        check("post_fl_row",   32'(iq.alloc_row), 32'd0);
        check_occ("post_fl_occ", 0);

        // ---- same-cycle wakeup bypass, then late wakeups ----
        dispatch(1'b1, 6'd5, 1'b0, 6'd2, 1'b1, 6'd20, 32'h1111_0000);
        iq.wb_valid = 1'b1;
        iq.wb_tag   = 6'd5;
        step();
        dispatch(1'b1, 6'd7, 1'b0, 6'd9, 1'b0, 6'd21, 32'h2222_0000);
        iq.wb_valid = 1'b0;
        settle();
        check("bypass_ready", 32'(iq.ready_entries), 32'b01);
        step();
        dispatch(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        iq.wb_valid = 1'b1;
        iq.wb_tag   = 6'd8;
        settle();
        check("g_not_ready", 32'(iq.ready_entries), 32'b01);
        step();
        iq.wb_tag = 6'd7;
        settle();
        check("wrong_tag", 32'(iq.ready_entries), 32'b01);
        step();
        iq.wb_tag = 6'd9;
        settle();
        check("src1_only", 32'(iq.ready_entries), 32'b01);
        step();
        iq.wb_valid = 1'b0;
        settle();
        check("both_woken", 32'(iq.ready_entries), 32'b11);

        // ---- grant on a non-ready row: issue_valid follows, no dealloc ----
        flush = 1'b1;
        step();
        flush = 1'b0;
        dispatch(1'b1, 6'd3, 1'b0, 6'd2, 1'b1, 6'd22, 32'h3333_0000);
        step();
        dispatch(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'h0);
        iq.grant_entry = 2'b01;
        iq.issue_ready = 1'b1;
        settle();
        check("nr_issue_v", 32'(iq.issue_valid), 32'd1);
        check("nr_payload", iq.issue_payload, 32'h3333_0000);
        step();
        iq.grant_entry = 2'b00;
        iq.issue_ready = 1'b0;
        settle();
        check("nr_kept_row", 32'(iq.alloc_row), 32'd1);
        check_occ("nr_occ", 1);
        iq.wb_valid = 1'b1;
        iq.wb_tag   = 6'd3;
        step();
        iq.wb_valid = 1'b0;
        settle();
        check("nr_woken", 32'(iq.ready_entries), 32'b01);

        // ---- asynchronous reset mid-cycle ----
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(iq.ready_entries), 32'd0);
        check("arst_disp",  32'(iq.disp_ready), 32'd1);
        check("arst_row",   32'(iq.alloc_row), 32'd0);
        check_occ("arst_occ", 0);
        #3;
        reset = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_issue_queue_alloc
`default_nettype wire

// File: doc/issue_queue_alloc.md
Name: issue_queue_alloc

Overview:
Storage and allocation side of the issue unit. Accepts micro-ops from dispatch and writes them into free issue-queue rows. Tracks source-operand readiness through result-tag wakeup broadcasts, and drives the age matrix with the insert row and the ready vector. Consumes the age matrix's one-hot grant, hands the granted micro-op downstream, and frees the row.

Parameters:
ENTRIES, 2, number of issue-queue rows (>=2, power of two)
TAG_W, 6, physical register tag width
PAYLOAD_W, 32, opaque micro-op payload width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush, invalidates all rows
disp_valid  input  1  dispatch offers a micro-op
disp_ready  output  1  a free row exists and no flush is active
disp_src1_tag  input  TAG_W  source 1 tag
disp_src1_rdy  input  1  source 1 already available
disp_src2_tag  input  TAG_W  source 2 tag
disp_src2_rdy  input  1  source 2 already available
disp_dst_tag  input  TAG_W  destination tag
disp_payload  input  PAYLOAD_W  micro-op payload
wb_valid  input  1  wakeup broadcast valid
wb_tag  input  TAG_W  wakeup tag
alloc_row  output  $clog2(ENTRIES)  row receiving the current dispatch
alloc_fire  output  1  disp_valid & disp_ready; drives the age-matrix update enable
ready_entries  output  ENTRIES  row valid and both sources ready
grant_entry  input  ENTRIES  one-hot oldest-ready grant from the age matrix
issue_valid  output  1  |grant_entry
issue_ready  input  1  downstream accepts the issued micro-op
issue_dst_tag  output  TAG_W  granted row's destination tag
issue_payload  output  PAYLOAD_W  granted row's payload

Behaviour:
- Reset (asynchronous, active-low, on clk):
  - All row valid and source-ready bits cleared.
  - disp_ready=1, ready_entries=0, issue_valid=0, alloc_row=0, alloc_fire=0.
  - Payload/tag storage is not reset; outputs are don't-care while issue_valid=0.
- Per-row state: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, dst_tag, payload.
- Allocation:
  - alloc_row is the lowest-index row with valid=0, computed from the registered state only.
  - disp_ready = (any row free) & !flush.
  - On alloc_fire, the row is written at the clock edge.
  - The srcN_rdy written is disp_srcN_rdy | (wb_valid & wb_tag==disp_srcN_tag) (same-cycle wakeup bypass).
- Wakeup: each cycle, every valid row with srcN_tag==wb_tag and wb_valid sets srcN_rdy at the next edge. Ready bits never clear except on dealloc, flush or reset.
- ready_entries[i] = valid[i] & src1_rdy[i] & src2_rdy[i], driven from registers. A dispatch at cycle t appears in ready_entries at t+1 at the earliest.
- Issue:
  - issue_valid, issue_dst_tag and issue_payload are combinational from grant_entry (mux on the one-hot).
  - Issue fires on issue_valid & issue_ready, and the granted row's valid clears at that edge.
  - With issue_ready=0, the row stays valid and the grant/outputs hold as supplied by the age matrix.
- Grant rules:
  - grant_entry must be one-hot or zero, and a subset of ready_entries.
  - A grant on a non-ready row is ignored (issue_valid still follows |grant, but no dealloc occurs). The bench flags this.
- Simultaneous dispatch and issue: the freed row is not reusable in the same cycle. When full, disp_ready=0 even while an issue fires; the dispatch is accepted the following cycle.
- Flush:
  - All valid bits clear at the edge; disp_ready=0 and alloc_fire=0 that cycle.
  - A concurrent issue fire is still presented downstream (the row is cleared by the flush).
  - Wakeup and dispatch during flush are dropped.
- Reset mid-operation: state clears immediately (asynchronous), with no partial issue.

Optional Feature:
- Macro ISSUE_QUEUE_OCCUPANCY_EN.
- When defined: adds output occupancy, width $clog2(ENTRIES+1), equal to the number of valid rows.
  - Registered, 0 at reset and after flush.
  - +1 on alloc_fire, -1 on an issue fire, unchanged when both occur.
- When undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then idle, ENTRIES=2 -> disp_ready=1, alloc_row=0, ready_entries=2'b00, issue_valid=0.
- Dispatch A (both rdy=1) then B (both rdy=1) on consecutive cycles, no grant -> alloc_row 0 then 1; ready_entries=2'b11 after the second edge; then disp_ready=0 and disp_valid held high gives alloc_fire=0.
- Dispatch A with src1_tag=5, src1_rdy=0 while wb_valid=1, wb_tag=5 -> next cycle ready_entries[0]=1 (bypass); repeat with wb the cycle after dispatch -> ready one cycle later.
- Full queue, grant_entry=2'b10, issue_ready=1, disp_valid=1 -> issue_payload is row 1's payload; row 1 frees at the edge; dispatch accepted next cycle into row 1.
- grant_entry=2'b01 with issue_ready=0 for 3 cycles, then 1 -> issue_valid high all 4 cycles, outputs stable, row 0 freed only after the 4th edge.
- Full queue, flush=1 with disp_valid=1 -> disp_ready=0 that cycle; next cycle ready_entries=0, disp_ready=1, occupancy=0 (feature on).
